// File: rtl/mario_motion_pkg.sv
// mario_pkg: shared definitions for Mario's motion controller and colour mapper.
// Contents:
//   KEY_RIGHT / KEY_LEFT / KEY_JUMP : USB HID keycodes that the controller reacts to
//   vstate_t                        : vertical motion state (GROUNDED, RISING, FALLING)
//   MARIO_SIZE                      : sprite edge length in pixels (also read by color_mapper)
//   wrap_add()                      : modular add using a single compare-and-subtract
package mario_pkg;

  localparam logic [7:0] KEY_RIGHT  = 8'h07;
  localparam logic [7:0] KEY_LEFT   = 8'h04;
  localparam logic [7:0] KEY_JUMP   = 8'h1A;
  localparam int         MARIO_SIZE = 16;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } vstate_t;

  // (base + step) mod modulus.
  // Valid only while base < modulus and step <= modulus,
  // which holds for the scroll offset.
  function automatic logic [9:0] wrap_add(input logic [9:0] base,
                                          input logic [9:0] step,
                                          input logic [9:0] modulus);
    logic [10:0] sum;
    logic [10:0] diff;
    sum  = {1'b0, base} + {1'b0, step};
    diff = sum - {1'b0, modulus};
    if (sum >= {1'b0, modulus}) begin
      wrap_add = diff[9:0];
    end else begin
      wrap_add = sum[9:0];
    end
  endfunction

endpackage

// File: rtl/mario_motion_if.sv
// mario_motion_if: keycode input and sprite-state outputs of the motion controller.
// Signals:
//   keycode     : current USB HID keycode (driven by the keyboard side)
//   MarioX/Y    : sprite top-left on screen
//   facing_left : 1 = draw mirrored
//   scroll_x    : world X of screen column 0
//   airborne    : 1 while jumping or falling
// Modports:
//   master : drives keycode, observes the sprite state
//   slave  : the motion controller itself
interface mario_motion_if;
  logic [7:0] keycode;
  logic [9:0] MarioX;
  logic [9:0] MarioY;
  logic       facing_left;
  logic [9:0] scroll_x;
  logic       airborne;

  modport master (output keycode,
                  input  MarioX, MarioY, facing_left, scroll_x, airborne);
  modport slave  (input  keycode,
                  output MarioX, MarioY, facing_left, scroll_x, airborne);
endinterface

// File: rtl/mario_motion_edge_sync.sv
// edge_sync: brings an asynchronous strobe into the Clk domain and emits a
// one-cycle pulse on each rising edge.
// Ports:
//   Clk, Reset_n : system clock and asynchronous active-low reset
//   async_in     : strobe from another clock domain (e.g. vsync)
//   pulse        : one-Clk-wide pulse, two cycles after the edge is first captured
module edge_sync (
  input  logic Clk,
  input  logic Reset_n,
  input  logic async_in,
  output logic pulse
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Two-flop synchronizer followed by a delay flop for edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign pulse = sync_r & ~prev_r;

endmodule

// File: rtl/mario_motion.sv
// mario_motion: per-frame motion controller for Mario.
// Turns the keycode into the sprite position, facing direction and world
// scroll offset. All state advances once per frame_clk rising edge.
// Ports:
//   Clk       : 50 MHz system clock
//   Reset_n   : asynchronous active-low reset
//   frame_clk : vsync-rate strobe, asynchronous to Clk
//   bus       : keycode in; MarioX, MarioY, facing_left, scroll_x, airborne out
//               (all outputs registered)
module mario_motion
  import mario_pkg::*;
#(
  parameter int START_X     = 64,
  parameter int GROUND_Y    = 416,
  parameter int SCROLL_EDGE = 240,
  parameter int WORLD_W     = 640,
  parameter int WALK_STEP   = 2,
  parameter int JUMP_V      = 10,
  parameter int MAX_FALL    = 8
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          frame_clk,
  mario_motion_if.slave bus
);

  localparam logic [9:0]         START_X10  = 10'(START_X);
  localparam logic [9:0]         GROUND_Y10 = 10'(GROUND_Y);
  localparam logic signed [10:0] GROUND_Y11 = 11'(GROUND_Y);
  localparam logic [9:0]         EDGE10     = 10'(SCROLL_EDGE);
  localparam logic [10:0]        EDGE11     = 11'(SCROLL_EDGE);
  localparam logic [9:0]         WORLD10    = 10'(WORLD_W);
  localparam logic [9:0]         STEP10     = 10'(WALK_STEP);
  localparam logic [10:0]        STEP11     = 11'(WALK_STEP);
  localparam logic signed [5:0]  VY_JUMP    = 6'(-JUMP_V);
  localparam logic signed [5:0]  VY_MAX     = 6'(MAX_FALL);

  logic              tick_s;
  vstate_t           state_r;
  vstate_t           state_nxt_s;
  logic [9:0]        x_r;
  logic [9:0]        x_nxt_s;
  logic [9:0]        y_r;
  logic [9:0]        y_nxt_s;
  logic [9:0]        scroll_r;
  logic [9:0]        scroll_nxt_s;
  logic              facing_r;
  logic              facing_nxt_s;
  logic              armed_r;
  logic              armed_nxt_s;
  logic              airborne_r;
  logic signed [5:0] vy_r;
  logic signed [5:0] vy_nxt_s;
  logic signed [5:0] vy_inc_s;
  logic signed [10:0] y_sum_s;
  logic [10:0]       x_step_s;
  logic              jump_req_s;

  edge_sync u_sync (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .async_in (frame_clk),
    .pulse    (tick_s)
  );

  // Y is widened to 11-bit signed so that going above row 0 or below the floor is visible
  assign y_sum_s    = $signed({1'b0, y_r}) + $signed({{5{vy_r[5]}}, vy_r});
  assign vy_inc_s   = vy_r + 6'sd1;
  assign x_step_s   = {1'b0, x_r} + STEP11;
  assign jump_req_s = (bus.keycode == KEY_JUMP) && armed_r;

  // Vertical FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= GROUNDED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Vertical FSM next-state logic, evaluated only on the frame tick
  always_comb begin
    state_nxt_s = state_r;
    if (tick_s) begin
      case (state_r)
        GROUNDED: begin
          if (jump_req_s) state_nxt_s = RISING;
          else            state_nxt_s = GROUNDED;
        end
        RISING: begin
          if ((y_sum_s < 11'sd0) || (vy_inc_s >= 6'sd0)) state_nxt_s = FALLING;
          else                                           state_nxt_s = RISING;
        end
        FALLING: begin
          if (y_sum_s >= GROUND_Y11) state_nxt_s = GROUNDED;
          else                       state_nxt_s = FALLING;
        end
        default: state_nxt_s = GROUNDED;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next values of position, velocity, scroll, facing and jump arming
  always_comb begin
    x_nxt_s      = x_r;
    y_nxt_s      = y_r;
    vy_nxt_s     = vy_r;
    scroll_nxt_s = scroll_r;
    facing_nxt_s = facing_r;
    armed_nxt_s  = armed_r;
    if (tick_s) begin
      if (bus.keycode == KEY_RIGHT) begin
        facing_nxt_s = 1'b0;
        if (x_step_s <= EDGE11) begin
          x_nxt_s = x_step_s[9:0];
        end else begin
          // Mario is pinned at the edge; the world moves instead
          x_nxt_s      = EDGE10;
          scroll_nxt_s = wrap_add(scroll_r, STEP10, WORLD10);
        end
      end else if (bus.keycode == KEY_LEFT) begin
        facing_nxt_s = 1'b1;
        if (x_r >= STEP10) x_nxt_s = x_r - STEP10;
        else               x_nxt_s = 10'd0;
      end else begin
        x_nxt_s = x_r;
      end

      // Any non-jump key re-arms; a jump launch below disarms
      if (bus.keycode != KEY_JUMP) armed_nxt_s = 1'b1;
      else                         armed_nxt_s = armed_r;

      case (state_r)
        GROUNDED: begin
          y_nxt_s = GROUND_Y10;
          if (jump_req_s) begin
            vy_nxt_s    = VY_JUMP;
            armed_nxt_s = 1'b0;
          end else begin
            vy_nxt_s = 6'sd0;
          end
        end
        RISING: begin
          if (y_sum_s < 11'sd0) begin
            y_nxt_s  = 10'd0;
            vy_nxt_s = 6'sd0;
          end else begin
            y_nxt_s  = y_sum_s[9:0];
            vy_nxt_s = vy_inc_s;
          end
        end
        FALLING: begin
          if (y_sum_s >= GROUND_Y11) begin
            y_nxt_s  = GROUND_Y10;
            vy_nxt_s = 6'sd0;
          end else begin
            y_nxt_s = y_sum_s[9:0];
            if (vy_inc_s > VY_MAX) vy_nxt_s = VY_MAX;
            else                   vy_nxt_s = vy_inc_s;
          end
        end
        default: begin
          y_nxt_s  = GROUND_Y10;
          vy_nxt_s = 6'sd0;
        end
      endcase
    end else begin
      y_nxt_s = y_r;
    end
  end

  // Datapath registers; airborne is registered from the next state so it tracks state_r
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      x_r        <= START_X10;
      y_r        <= GROUND_Y10;
      vy_r       <= 6'sd0;
      scroll_r   <= 10'd0;
      facing_r   <= 1'b0;
      armed_r    <= 1'b1;
      airborne_r <= 1'b0;
    end else begin
      x_r        <= x_nxt_s;
      y_r        <= y_nxt_s;
      vy_r       <= vy_nxt_s;
      scroll_r   <= scroll_nxt_s;
      facing_r   <= facing_nxt_s;
      armed_r    <= armed_nxt_s;
      airborne_r <= (state_nxt_s != GROUNDED);
    end
  end

  assign bus.MarioX      = x_r;
  assign bus.MarioY      = y_r;
  assign bus.facing_left = facing_r;
  assign bus.scroll_x    = scroll_r;
  assign bus.airborne    = airborne_r;

endmodule

// File: tb/tb_mario_motion.sv
// Bench for mario_motion.
// The driver issues frame ticks and pushes the expected sprite state into a
// scoreboard queue. The monitor pops one entry three Clk edges after each
// frame_clk rise and compares it with the DUT outputs.
module tb_mario_motion;

  logic Clk       = 1'b0;
  logic Reset_n   = 1'b0;
  logic frame_clk = 1'b0;

  mario_motion_if bus ();

  mario_motion dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    int x;
    int y;
    int scroll;
    bit facing;
    bit air;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: plain integers; the jump arc is a precomputed list of Y values
  int m_x;
  int m_y;
  int m_scroll;
  bit m_facing;
  bit m_armed;
  int traj_q[$];

  function automatic void model_reset();
    m_x      = 64;
    m_y      = 416;
    m_scroll = 0;
    m_facing = 1'b0;
    m_armed  = 1'b1;
    traj_q.delete();
  endfunction

  // Y positions for every tick after launch, ending with the landing at 416
  function automatic void build_arc();
    int y  = 416;
    int v  = -10;
    bit up = 1'b1;
    traj_q.delete();
    forever begin
      if (up) begin
        y = y + v;
        v = v + 1;
        if (y < 0) begin
          y  = 0;
          v  = 0;
          up = 1'b0;
        end else if (v >= 0) begin
          up = 1'b0;
        end
        traj_q.push_back(y);
      end else begin
        if (y + v >= 416) begin
          traj_q.push_back(416);
          break;
        end
        y = y + v;
        v = (v + 1 > 8) ? 8 : v + 1;
        traj_q.push_back(y);
      end
    end
  endfunction

  function automatic void model_tick(input logic [7:0] key);
    if (key == 8'h07) begin
      m_facing = 1'b0;
      if (m_x + 2 <= 240) begin
        m_x = m_x + 2;
      end else begin
        m_x      = 240;
        m_scroll = (m_scroll + 2) % 640;
      end
    end else if (key == 8'h04) begin
      m_facing = 1'b1;
      m_x      = (m_x - 2 < 0) ? 0 : m_x - 2;
    end
    if (traj_q.size() != 0) begin
      m_y = traj_q.pop_front();
    end else if (key == 8'h1A && m_armed) begin
      build_arc();
      m_armed = 1'b0;
    end
    if (key != 8'h1A) m_armed = 1'b1;
  endfunction

  task automatic do_tick(input logic [7:0] key);
    exp_t e;
    @(negedge Clk);
    bus.keycode = key;
    model_tick(key);
    e.x      = m_x;
    e.y      = m_y;
    e.scroll = m_scroll;
    e.facing = m_facing;
    e.air    = (traj_q.size() != 0);
    sb_q.push_back(e);
    frame_clk = 1'b1;
    repeat (6) @(negedge Clk);
    // Keycode noise between ticks must be ignored
    bus.keycode = 8'($urandom);
    frame_clk   = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic check_state(input string name, input exp_t e);
    vectors++;
    if (int'(bus.MarioX) != e.x || int'(bus.MarioY) != e.y ||
        int'(bus.scroll_x) != e.scroll || bus.facing_left != e.facing ||
        bus.airborne != e.air) begin
      miscompares++;
      $display("FAIL %s: got x=%0d y=%0d scroll=%0d facing=%0b air=%0b, expected x=%0d y=%0d scroll=%0d facing=%0b air=%0b",
               name, bus.MarioX, bus.MarioY, bus.scroll_x, bus.facing_left, bus.airborne,
               e.x, e.y, e.scroll, e.facing, e.air);
    end
  endtask

  // Monitor: one comparison per frame tick, after the 3-cycle update latency
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard: DUT update with no expected entry queued");
      end else begin
        e = sb_q.pop_front();
        check_state("tick", e);
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_reset_values(input string name);
    exp_t e;
    e.x      = 64;
    e.y      = 416;
    e.scroll = 0;
    e.facing = 1'b0;
    e.air    = 1'b0;
    check_state(name, e);
  endtask

  initial begin
    logic [7:0] k;
    bus.keycode = 8'h00;
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset_values("reset_initial");
    Reset_n = 1'b1;

    // Walk right: edge at tick 88, then scroll up to 638 and wrap to 0
    for (int i = 0; i < 410; i++) do_tick(8'h07);

    // Walk left down to and past the left clamp
    for (int i = 0; i < 125; i++) do_tick(8'h04);

    // Single jump arc
    do_tick(8'h1A);
    for (int i = 0; i < 25; i++) do_tick(8'h00);

    // Held jump: only one jump; release then press again jumps
    for (int i = 0; i < 30; i++) do_tick(8'h1A);
    do_tick(8'h00);
    do_tick(8'h1A);
    for (int i = 0; i < 25; i++) do_tick(8'h00);

    // Reset mid-jump, checked between Clk edges
    for (int i = 0; i < 20; i++) do_tick(8'h07);
    do_tick(8'h1A);
    for (int i = 0; i < 4; i++) do_tick(8'h00);
    @(negedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    check_reset_values("reset_mid_jump");
    model_reset();
    @(negedge Clk);
    Reset_n = 1'b1;

    // Random keycode mix
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0:       k = 8'h07;
        1:       k = 8'h04;
        2:       k = 8'h1A;
        3:       k = 8'h00;
        default: k = 8'($urandom);
      endcase
      do_tick(k);
    end

    repeat (20) @(negedge Clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mario_motion.md
# mario_motion

Per-frame motion controller that turns the USB keycode into Mario's screen position, facing direction and horizontal world scroll offset. It sits directly upstream of `color_mapper`. It drives the sprite origin (`BallX`/`BallY`), the left-mirror select and the background tile column offset that `color_mapper` consumes. State updates once per video frame, with jump/gravity handled by a three-state vertical FSM.

## Interface

Parameters:
- `START_X`, 64: reset X of sprite top-left (px)
- `GROUND_Y`, 416: Y of sprite top-left when standing on floor (px)
- `SCROLL_EDGE`, 240: rightmost screen X Mario may reach before the world scrolls instead
- `WORLD_W`, 640: world width in px (40 tiles × 16); scroll wraps modulo this
- `WALK_STEP`, 2: horizontal px per frame
- `JUMP_V`, 10: initial upward speed (px/frame)
- `MAX_FALL`, 8: terminal downward speed (px/frame)

Ports:
- `Clk` in 1: 50 MHz system clock
- `Reset_n` in 1: asynchronous, active-low reset
- `frame_clk` in 1: VGA vsync-rate strobe, asynchronous to `Clk`
- `keycode` in 8: current USB HID keycode (0x07 right, 0x04 left, 0x1A jump, else none)
- `MarioX` out 10: sprite top-left X on screen
- `MarioY` out 10: sprite top-left Y on screen
- `facing_left` out 1: 1 = draw mirrored
- `scroll_x` out 10: world X of screen column 0, in range 0..WORLD_W-1
- `airborne` out 1: 1 when the FSM is not GROUNDED

## Operation

**Frame tick.** `frame_clk` passes through a 2-flop synchronizer and a rising-edge detector, which produces a one-`Clk` pulse `tick`. All state below updates only on `tick`.

**Horizontal** (evaluated each tick):
- Keycode 0x07:
  - `facing_left` ← 0.
  - If `MarioX + WALK_STEP <= SCROLL_EDGE`, `MarioX` += WALK_STEP.
  - Otherwise `MarioX` ← SCROLL_EDGE and `scroll_x` ← (`scroll_x` + WALK_STEP) mod WORLD_W.
- Keycode 0x04:
  - `facing_left` ← 1.
  - `MarioX` ← max(`MarioX` − WALK_STEP, 0), clamped with no underflow.
  - The world never scrolls left.
- Any other keycode: no horizontal change.

**Vertical FSM.** `vy` is a signed 6-bit velocity, negative = up.
- **GROUNDED**:
  - If keycode == 0x1A and `jump_armed`: `vy` ← −JUMP_V, `jump_armed` ← 0, go to RISING. Y does not move this tick.
  - Otherwise `MarioY` holds at GROUND_Y.
- **RISING**:
  - `MarioY` += `vy`, then `vy` += 1.
  - If the new Y would be < 0: `MarioY` ← 0, `vy` ← 0, go to FALLING.
  - When the updated `vy` ≥ 0, go to FALLING.
- **FALLING**:
  - ny = `MarioY` + `vy`.
  - If ny ≥ GROUND_Y: `MarioY` ← GROUND_Y, `vy` ← 0, go to GROUNDED.
  - Otherwise `MarioY` ← ny and `vy` ← min(`vy` + 1, MAX_FALL).

**Jump re-arm.** `jump_armed` is set on any tick where keycode ≠ 0x1A. Holding jump therefore never triggers a second jump after landing.

**Arithmetic.** Y is computed in 11-bit signed to detect underflow and overshoot. Scroll wrap uses compare-and-subtract, not a divider.

## Timing

- Reset (async assert, sync-free deassert effect on next `Clk`):
  - `MarioX` = START_X, `MarioY` = GROUND_Y, `scroll_x` = 0.
  - `facing_left` = 0, `airborne` = 0, `vy` = 0.
  - FSM = GROUNDED, `jump_armed` = 1, synchronizer flops = 0.
- Latency: `frame_clk` rising edge → outputs updated 3 `Clk` cycles later (2 sync + 1 register). Outputs are stable for the remainder of the frame.
- `keycode` is sampled only in the tick cycle. Changes between ticks are ignored.
- Reset mid-jump returns Mario immediately to the floor at START_X. No partial frame update occurs.
- A `frame_clk` glitch shorter than 2 `Clk` periods may be missed. This is acceptable.
- All outputs are registered. There is no combinational path from `keycode` to the outputs.

## Structure

- Shared package `mario_pkg`:
  - keycode constants `KEY_RIGHT`, `KEY_LEFT`, `KEY_JUMP`
  - enum `vstate_t {GROUNDED, RISING, FALLING}`
  - `MARIO_SIZE` = 16 (also used by `color_mapper`)
- One sub-module, `edge_sync`: 2-flop synchronizer plus rising-edge pulse, with `Clk`/`Reset_n`. It is reusable for other vsync-driven blocks.

## Test plan

1. **Reset.** Assert `Reset_n`=0 mid-jump → `MarioX`=64, `MarioY`=416, `scroll_x`=0, `airborne`=0 within 1 cycle, without waiting for a `Clk` edge.
2. **Walk right.** Hold 0x07 for 100 ticks → `MarioX` reaches 240 at tick 88. Over the next 12 ticks `scroll_x` reaches 24, with `facing_left`=0.
3. **Scroll wrap.** Preload `scroll_x`=638 at the edge, 1 tick of 0x07 → `scroll_x`=0, `MarioX`=240.
4. **Left clamp.** From `MarioX`=1, 1 tick of 0x04 → `MarioX`=0 and `facing_left`=1. A further tick leaves `MarioX`=0.
5. **Jump arc.** Press 0x1A for 1 tick, then release:
   - Y sequence after launch: 406, 397, 389, … with peak Y = 416 − 55 = 361 when `vy` reaches 0.
   - Then falling, landing exactly at Y=416 with `airborne`→0.
   - Total airtime matches the computed sequence.
6. **Held jump.** Hold 0x1A continuously through the landing → no second jump. Releasing for 1 tick and pressing again starts a new jump.
